// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode sequencer feeding the microcode ROM groups
module instr_sequencer #(
  parameter int         EXEC_CYCLES = 1,
  parameter logic [7:0] PC_RST      = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  input  logic       stall,
  output logic [1:0] en,
  output logic [7:0] instr,
  output logic [7:0] pc,
  output logic       busy,
  output logic       halted,
  output logic       err
);

  // Countdown only needs to hold EXEC_CYCLES-1; keep at least one bit.
  localparam int            CW       = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(EXEC_CYCLES - 1);

  localparam logic [2:0] st_idle    = 3'd0;
  localparam logic [2:0] st_fetch   = 3'd1;
  localparam logic [2:0] st_decode  = 3'd2;
  localparam logic [2:0] st_exec    = 3'd3;
  localparam logic [2:0] st_operand = 3'd4;
  localparam logic [2:0] st_halt    = 3'd5;

  logic [2:0]    state;
  logic [7:0]    ir;
  logic [CW-1:0] cnt;

  // Address and instruction outputs are direct register taps.
  assign mem_addr = pc;
  assign instr    = ir;

  // Sequencer state machine; every output flag is updated together with the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= st_idle;
      pc      <= PC_RST;
      ir      <= 8'h00;
      cnt     <= '0;
      en      <= 2'b00;
      mem_req <= 1'b0;
      busy    <= 1'b0;
      halted  <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        st_idle: begin
          if (run) begin
            state   <= st_fetch;
            mem_req <= 1'b1;
            busy    <= 1'b1;
          end
        end

        // A request, once raised, is held until acknowledged regardless of run.
        st_fetch: begin
          if (mem_ack) begin
            ir      <= mem_data;
            pc      <= pc + 8'd1;
            mem_req <= 1'b0;
            state   <= st_decode;
          end
        end

        st_decode: begin
          if (ir[7:4] <= 4'h2) begin
            // Class code 0/1/2 maps onto ROM group select 01/10/11.
            state <= st_exec;
            en    <= ir[5:4] + 2'd1;
            cnt   <= CNT_LOAD;
          end else if (ir[7:4] == 4'h3) begin
            state   <= st_operand;
            mem_req <= 1'b1;
          end else if (ir == 8'hFF) begin
            state  <= st_halt;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            // Illegal opcode: flag it and continue as a NOP.
            err <= 1'b1;
            if (run) begin
              state   <= st_fetch;
              mem_req <= 1'b1;
            end else begin
              state <= st_idle;
              busy  <= 1'b0;
            end
          end
        end

        // Stall freezes the countdown with en/instr held steady.
        st_exec: begin
          if (!stall) begin
            if (cnt == '0) begin
              en <= 2'b00;
              if (run) begin
                state   <= st_fetch;
                mem_req <= 1'b1;
              end else begin
                state <= st_idle;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end

        // JMP target byte replaces pc outright; no increment.
        st_operand: begin
          if (mem_ack) begin
            pc <= mem_data;
            if (run) begin
              state <= st_fetch;
            end else begin
              state   <= st_idle;
              mem_req <= 1'b0;
              busy    <= 1'b0;
            end
          end
        end

        st_halt: begin
          state <= st_halt;
        end

        default: begin
          state   <= st_idle;
          en      <= 2'b00;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
